// File: rtl/hacd_pkg.sv
// Shared types and constants for the HACD translation front end.
package hacd_pkg;

    localparam int HACD_AXI4_ADDR_WIDTH = 32;
    localparam int HPPA_W               = HACD_AXI4_ADDR_WIDTH - 12;
    localparam int TF_CACHE_ENTRIES     = 4;
    localparam int TF_STATE_W           = 3;

    // Host physical addresses at or above this base are translated; below it they pass through.
    localparam logic [HACD_AXI4_ADDR_WIDTH-1:0] HPPA_BASE_ADDR = 32'h1000_0000;

    typedef enum logic [TF_STATE_W-1:0] {
        TF_IDLE        = 3'd0,
        TF_HIT_OUT     = 3'd1,
        TF_LOOKUP      = 3'd2,
        TF_WAIT_ACCESS = 3'd3,
        TF_FILL_OUT    = 3'd4
    } tf_state_e;

    typedef struct packed {
        logic              valid;
        logic [HPPA_W-1:0] hppa;
        logic [HPPA_W-1:0] ppa;
    } tf_entry_t;

    typedef struct packed {
        logic              lookup;
        logic [HPPA_W-1:0] hppa;
        logic              zeroBlkWr;
    } att_lkup_reqpkt_t;

    typedef struct packed {
        logic                            allow_access;
        logic [HACD_AXI4_ADDR_WIDTH-1:0] ppa;
        logic [1:0]                      sts;
    } trnsl_reqpkt_t;

endpackage

// File: rtl/hawk_trnsl_front.sv
// Translation front end: caches host-page to physical-page mappings in a small
// fully-associative table and asks the page-read manager on a miss.
module hawk_trnsl_front
    import hacd_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [HACD_AXI4_ADDR_WIDTH-1:0] req_addr,
    input  logic                            req_zero_blk,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [HACD_AXI4_ADDR_WIDTH-1:0] out_addr,
    output logic                            out_bypass,
    output att_lkup_reqpkt_t                lkup_reqpkt,
    input  logic                            pgrd_mngr_ready,
    input  trnsl_reqpkt_t                   trnsl_reqpkt,
    input  logic                            inv_valid,
    input  logic [HPPA_W-1:0]               inv_hppa,
    output logic [TF_STATE_W-1:0]           tf_state
);

    tf_entry_t [TF_CACHE_ENTRIES-1:0] r_cache;
    logic [1:0]                       r_vptr;
    tf_state_e                        r_state;
    tf_state_e                        w_state_nxt;
    logic [HACD_AXI4_ADDR_WIDTH-1:0]  r_addr;
    logic                             r_zero;
    logic [HACD_AXI4_ADDR_WIDTH-1:0]  r_out_addr;
    logic                             r_out_bypass;

    logic [TF_CACHE_ENTRIES-1:0]      w_valid_raw;
    logic [TF_CACHE_ENTRIES-1:0]      w_inv_match;
    logic [TF_CACHE_ENTRIES-1:0]      w_valid_eff;
    logic [TF_CACHE_ENTRIES-1:0]      w_hit_vec;
    logic                             w_hit;
    logic [1:0]                       w_hit_idx;
    logic [1:0]                       w_victim;
    logic                             w_bypass;
    logic                             w_fill_blk;
    logic                             w_lookup;
    logic                             w_fill;
    logic                             w_accept;

    // Only the page-number part of the returned ppa and no status bits are consumed here.
    logic w_unused_ok;
    assign w_unused_ok = ^{trnsl_reqpkt.sts, trnsl_reqpkt.ppa[11:0]};

    // CAM compare of one tag against every entry, gated by a per-entry valid vector.
    function automatic logic [TF_CACHE_ENTRIES-1:0] cam_match(
        input tf_entry_t [TF_CACHE_ENTRIES-1:0] entries,
        input logic [TF_CACHE_ENTRIES-1:0]      vld,
        input logic [HPPA_W-1:0]                tag
    );
        logic [TF_CACHE_ENTRIES-1:0] m;
        for (int i = 0; i < TF_CACHE_ENTRIES; i++) begin
            m[i] = vld[i] && (entries[i].hppa == tag);
        end
        return m;
    endfunction

    // Hit and victim selection see the cache as it is after this cycle's invalidation.
    always_comb begin
        for (int i = 0; i < TF_CACHE_ENTRIES; i++) begin
            w_valid_raw[i] = r_cache[i].valid;
        end
        w_inv_match = inv_valid ? cam_match(r_cache, w_valid_raw, inv_hppa) : '0;
        w_valid_eff = w_valid_raw & ~w_inv_match;
        w_hit_vec   = cam_match(r_cache, w_valid_eff, req_addr[HACD_AXI4_ADDR_WIDTH-1:12]);
        w_hit       = |w_hit_vec;
        w_hit_idx   = '0;
        w_victim    = r_vptr;
        for (int i = TF_CACHE_ENTRIES - 1; i >= 0; i--) begin
            if (w_hit_vec[i])    w_hit_idx = 2'(i);
            if (!w_valid_eff[i]) w_victim  = 2'(i);
        end
        w_bypass   = req_addr < HPPA_BASE_ADDR;
        w_fill_blk = inv_valid && (inv_hppa == r_addr[HACD_AXI4_ADDR_WIDTH-1:12]);
        w_accept   = (r_state == TF_IDLE) && req_valid;
        w_fill     = (r_state == TF_WAIT_ACCESS) && trnsl_reqpkt.allow_access;
    end

    // Next-state logic; the lookup strobe is a Mealy output of LOOKUP.
    always_comb begin
        w_state_nxt = r_state;
        w_lookup    = 1'b0;
        case (r_state)
            TF_IDLE: begin
                if (req_valid) w_state_nxt = (w_bypass || w_hit) ? TF_HIT_OUT : TF_LOOKUP;
            end
            TF_LOOKUP: begin
                if (pgrd_mngr_ready) begin
                    w_lookup    = 1'b1;
                    w_state_nxt = TF_WAIT_ACCESS;
                end
            end
            TF_WAIT_ACCESS: begin
                if (trnsl_reqpkt.allow_access) w_state_nxt = TF_FILL_OUT;
            end
            TF_HIT_OUT, TF_FILL_OUT: begin
                if (out_ready) w_state_nxt = TF_IDLE;
            end
            default: w_state_nxt = TF_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= TF_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Request capture and the held output address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr       <= '0;
            r_zero       <= 1'b0;
            r_out_addr   <= '0;
            r_out_bypass <= 1'b0;
        end else if (w_accept) begin
            r_addr       <= req_addr;
            r_zero       <= req_zero_blk;
            r_out_bypass <= w_bypass;
            if (w_bypass) r_out_addr <= req_addr;
            else if (w_hit) r_out_addr <= {r_cache[w_hit_idx].ppa, req_addr[11:0]};
        end else if (w_fill) begin
            r_out_addr   <= {trnsl_reqpkt.ppa[HACD_AXI4_ADDR_WIDTH-1:12], r_addr[11:0]};
            r_out_bypass <= 1'b0;
        end
    end

    // Cache maintenance: invalidate matches, then install a fill unless it was invalidated this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cache <= '0;
            r_vptr  <= '0;
        end else begin
            for (int i = 0; i < TF_CACHE_ENTRIES; i++) begin
                if (w_inv_match[i]) r_cache[i].valid <= 1'b0;
            end
            if (w_fill) begin
                r_vptr <= r_vptr + 2'd1;
                if (!w_fill_blk) begin
                    r_cache[w_victim] <= '{valid: 1'b1,
                                           hppa:  r_addr[HACD_AXI4_ADDR_WIDTH-1:12],
                                           ppa:   trnsl_reqpkt.ppa[HACD_AXI4_ADDR_WIDTH-1:12]};
                end
            end
        end
    end

    assign req_ready             = (r_state == TF_IDLE) && rst_ni;
    assign out_valid             = (r_state == TF_HIT_OUT) || (r_state == TF_FILL_OUT);
    assign out_addr              = r_out_addr;
    assign out_bypass            = r_out_bypass;
    assign lkup_reqpkt.lookup    = w_lookup;
    assign lkup_reqpkt.hppa      = w_lookup ? r_addr[HACD_AXI4_ADDR_WIDTH-1:12] : '0;
    assign lkup_reqpkt.zeroBlkWr = w_lookup & r_zero;
    assign tf_state              = r_state;

endmodule

// File: tb/tb_hawk_trnsl_front.sv
// Self-checking bench for hawk_trnsl_front with a page-level cache reference model.
module tb_hawk_trnsl_front;
    import hacd_pkg::*;

    localparam int AW = HACD_AXI4_ADDR_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [AW-1:0]        req_addr = '0;
    logic                 req_zero_blk = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [AW-1:0]        out_addr;
    logic                 out_bypass;
    att_lkup_reqpkt_t     lkup_reqpkt;
    logic                 pgrd_mngr_ready = 1'b1;
    trnsl_reqpkt_t        trnsl_reqpkt = '0;
    logic                 inv_valid = 1'b0;
    logic [HPPA_W-1:0]    inv_hppa = '0;
    logic [TF_STATE_W-1:0] tf_state;

    hawk_trnsl_front dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_zero_blk   (req_zero_blk),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_bypass     (out_bypass),
        .lkup_reqpkt    (lkup_reqpkt),
        .pgrd_mngr_ready(pgrd_mngr_ready),
        .trnsl_reqpkt   (trnsl_reqpkt),
        .inv_valid      (inv_valid),
        .inv_hppa       (inv_hppa),
        .tf_state       (tf_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int lk_cnt   = 0;

    always @(posedge clk) if (lkup_reqpkt.lookup === 1'b1) lk_cnt <= lk_cnt + 1;

    // Reference model: a 4-slot page table plus a rotating replacement index.
    bit                m_v [4];
    logic [HPPA_W-1:0] m_h [4];
    logic [HPPA_W-1:0] m_p [4];
    int                m_ptr;

    function automatic int m_find(input logic [HPPA_W-1:0] pg);
        for (int i = 0; i < 4; i++) if (m_v[i] && m_h[i] == pg) return i;
        return -1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic m_inv(input logic [HPPA_W-1:0] pg);
        for (int i = 0; i < 4; i++) if (m_h[i] == pg) m_v[i] = 1'b0;
    endtask

    task automatic m_fill(input logic [HPPA_W-1:0] pg, input logic [HPPA_W-1:0] pp, input bit blocked);
        int slot;
        if (!blocked) begin
            slot = -1;
            for (int i = 0; i < 4; i++) if (!m_v[i] && slot < 0) slot = i;
            if (slot < 0) slot = m_ptr;
            m_v[slot] = 1'b1;
            m_h[slot] = pg;
            m_p[slot] = pp;
        end
        m_ptr = (m_ptr + 1) % 4;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_valid = 1'b0;
        out_ready = 1'b0;
        inv_valid = 1'b0;
        trnsl_reqpkt = '0;
        pgrd_mngr_ready = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_bypass", out_bypass, 0);
        chk("rst_lkup", lkup_reqpkt, 0);
        chk("rst_tf_state", tf_state, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        #1;
        chk("rel_req_ready", req_ready, 1);
        chk("rel_tf_state", tf_state, 0);
        m_clear();
    endtask

    task automatic inv_pulse(input logic [HPPA_W-1:0] pg);
        inv_valid = 1'b1;
        inv_hppa  = pg;
        @(posedge clk); #1;
        inv_valid = 1'b0;
        m_inv(pg);
    endtask

    // One request from handshake to output acceptance, checked against the model.
    task automatic txn(input logic [AW-1:0] addr, input bit zero, input logic [AW-1:0] ppa,
                       input int pgrd_dly, input int lat, input int stall,
                       input bit inv_fill, input bit inv_hold, input bit inv_hs);
        int            lk0;
        int            idx;
        bit            miss;
        logic [AW-1:0] exp_addr;
        bit            exp_byp;
        lk0 = lk_cnt;
        pgrd_mngr_ready = (pgrd_dly == 0);
        req_valid    = 1'b1;
        req_addr     = addr;
        req_zero_blk = zero;
        if (inv_hs) begin
            inv_valid = 1'b1;
            inv_hppa  = addr[AW-1:12];
            m_inv(addr[AW-1:12]);
        end
        chk("req_ready_idle", req_ready, 1);
        miss = 1'b0;
        exp_byp = 1'b0;
        exp_addr = '0;
        if (addr < HPPA_BASE_ADDR) begin
            exp_byp  = 1'b1;
            exp_addr = addr;
        end else begin
            idx = m_find(addr[AW-1:12]);
            if (idx >= 0) exp_addr = {m_p[idx], addr[11:0]};
            else miss = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        inv_valid = 1'b0;
        if (!miss) begin
            chk("hit_out_valid", out_valid, 1);
        end else begin
            chk("miss_out_valid", out_valid, 0);
            for (int c = 0; c < pgrd_dly; c++) begin
                chk("stall_lookup", lkup_reqpkt.lookup, 0);
                chk("stall_req_ready", req_ready, 0);
                @(posedge clk); #1;
            end
            pgrd_mngr_ready = 1'b1;
            #1;
            chk("lookup_pulse", lkup_reqpkt.lookup, 1);
            chk("lookup_hppa", lkup_reqpkt.hppa, addr[AW-1:12]);
            chk("lookup_zero", lkup_reqpkt.zeroBlkWr, zero);
            @(posedge clk); #1;
            chk("lookup_single", lkup_reqpkt.lookup, 0);
            repeat (lat) begin
                @(posedge clk); #1;
            end
            chk("wait_out_valid", out_valid, 0);
            trnsl_reqpkt = '{allow_access: 1'b1, ppa: ppa, sts: 2'b00};
            if (inv_fill) begin
                inv_valid = 1'b1;
                inv_hppa  = addr[AW-1:12];
            end
            @(posedge clk); #1;
            trnsl_reqpkt = '0;
            inv_valid    = 1'b0;
            m_fill(addr[AW-1:12], ppa[AW-1:12], inv_fill);
            exp_addr = {ppa[AW-1:12], addr[11:0]};
            chk("fill_out_valid", out_valid, 1);
        end
        chk("out_addr", out_addr, exp_addr);
        chk("out_bypass", out_bypass, exp_byp);
        out_ready = 1'b0;
        for (int c = 0; c < stall; c++) begin
            if (c == 0 && inv_hold) begin
                inv_valid = 1'b1;
                inv_hppa  = addr[AW-1:12];
                m_inv(addr[AW-1:12]);
            end
            @(posedge clk); #1;
            inv_valid = 1'b0;
            chk("held_out_valid", out_valid, 1);
            chk("held_out_addr", out_addr, exp_addr);
            chk("held_out_bypass", out_bypass, exp_byp);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("done_out_valid", out_valid, 0);
        chk("done_req_ready", req_ready, 1);
        chk("lookup_count", lk_cnt - lk0, miss ? 1 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] p;
        int            k;

        do_reset();

        // Cold miss with a slow grant, then a hit to the same page.
        txn(HPPA_BASE_ADDR + 32'h1234, 1'b0, 32'h8000_5000, 0, 20, 0, 0, 0, 0);
        chk("first_translation", out_addr, 32'h8000_5234);
        txn(HPPA_BASE_ADDR + 32'h1010, 1'b0, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("second_translation", out_addr, 32'h8000_5010);

        // Pass-through address with a stalled consumer.
        txn(32'h0000_1000, 1'b0, 32'h0, 0, 0, 3, 0, 0, 0);

        // Page-read manager busy for 50 cycles.
        txn(HPPA_BASE_ADDR + 32'h7abc, 1'b1, 32'h9000_7000, 50, 2, 1, 0, 0, 0);

        // Fill invalidated in the grant cycle still translates, then misses again.
        txn(HPPA_BASE_ADDR + 32'h8040, 1'b0, 32'hA000_8000, 0, 3, 0, 1, 0, 0);
        txn(HPPA_BASE_ADDR + 32'h8020, 1'b0, 32'hA100_8000, 0, 1, 0, 0, 0, 0);

        // Invalidation while a hit is being held, and at the handshake itself.
        txn(HPPA_BASE_ADDR + 32'h1100, 1'b0, 32'h0, 0, 0, 2, 0, 1, 0);
        txn(HPPA_BASE_ADDR + 32'h7000, 1'b0, 32'hB000_7000, 0, 0, 0, 0, 0, 1);

        // Round-robin eviction across five distinct pages.
        do_reset();
        for (int i = 1; i <= 5; i++)
            txn(HPPA_BASE_ADDR + 32'(i) * 32'h1000 + 32'h44, 1'b0, 32'hC000_0000 + 32'(i) * 32'h1000, 0, 1, 0, 0, 0, 0);
        k = lk_cnt;
        for (int i = 2; i <= 5; i++)
            txn(HPPA_BASE_ADDR + 32'(i) * 32'h1000 + 32'h8, 1'b0, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("pages2to5_no_lookup", lk_cnt - k, 0);
        txn(HPPA_BASE_ADDR + 32'h1008, 1'b0, 32'hC000_1000, 0, 1, 0, 0, 0, 0);
        chk("page1_evicted_lookup", lk_cnt - k, 1);

        // Reset while waiting for a grant drops the request.
        req_valid = 1'b1;
        req_addr  = HPPA_BASE_ADDR + 32'h9000;
        pgrd_mngr_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("in_wait_state", tf_state, 3'd3);
        rst_ni = 1'b0;
        #1;
        chk("async_rst_state", tf_state, 0);
        chk("async_rst_ready", req_ready, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        m_clear();
        trnsl_reqpkt = '{allow_access: 1'b1, ppa: 32'hD000_9000, sts: 2'b00};
        @(posedge clk); #1;
        trnsl_reqpkt = '0;
        chk("stale_grant_state", tf_state, 0);
        chk("stale_grant_out_valid", out_valid, 0);
        txn(HPPA_BASE_ADDR + 32'h9010, 1'b0, 32'hD100_9000, 0, 0, 0, 0, 0, 0);

        // Randomized traffic over a small page pool.
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 6);
            if (k == 0) a = 32'h0000_1000 + ($urandom_range(0, 3) << 12) + ($urandom & 32'hFFF);
            else        a = HPPA_BASE_ADDR + 32'(k) * 32'h1000 + ($urandom & 32'hFFF);
            p = $urandom & 32'hFFFF_F000;
            txn(a, 1'($urandom_range(0, 1)), p, $urandom_range(0, 2), $urandom_range(0, 5),
                $urandom_range(0, 3), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 5) == 0) inv_pulse(HPPA_W'(HPPA_BASE_ADDR[AW-1:12] + $urandom_range(1, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/hawk_trnsl_front.md
HAWK_TRNSL_FRONT -- requirements
Module: hawk_trnsl_front

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: req_valid in 1, req_ready out 1, req_addr in HACD_AXI4_ADDR_WIDTH, req_zero_blk in 1; these carry host AXI address requests, one per valid/ready handshake.
REQ-003 SHALL have ports: out_valid out 1, out_ready in 1, out_addr out HACD_AXI4_ADDR_WIDTH, out_bypass out 1; these carry the translated address to the AXI master side.
REQ-004 SHALL have port lkup_reqpkt out hacd_pkg::att_lkup_reqpkt_t (lookup, hppa[ADDR-1:12], zeroBlkWr), which drives the page-read manager.
REQ-005 SHALL have ports: pgrd_mngr_ready in 1; trnsl_reqpkt in hacd_pkg::trnsl_reqpkt_t (allow_access, ppa byte address, sts).
REQ-006 SHALL have ports: inv_valid in 1, inv_hppa in [ADDR-1:12]; these invalidate a cached translation when a page is compressed or migrated.
REQ-007 SHALL have debug port tf_state out 3, which carries the current FSM state.

Function
REQ-008 SHALL hold a 4-entry fully-associative translation cache {valid, hppa, ppa[ADDR-1:12]} with round-robin 2-bit victim pointer.
REQ-009 Requests with req_addr < HPPA_BASE_ADDR SHALL bypass translation: out_addr = req_addr, out_bypass = 1, and the cache and lookup are not touched.
REQ-010 FSM states SHALL be IDLE, HIT_OUT, LOOKUP, WAIT_ACCESS, FILL_OUT.
REQ-011 req_ready SHALL be 1 only in IDLE; the handshake SHALL capture req_addr and req_zero_blk into registers.
REQ-012 On an IDLE handshake with a cache hit or bypass, the FSM SHALL go to HIT_OUT. out_valid SHALL assert the next cycle (1-cycle latency). out_addr SHALL be {entry.ppa, req_addr[11:0]}.
REQ-013 On an IDLE handshake with a miss, the FSM SHALL go to LOOKUP.
REQ-014 In LOOKUP, when pgrd_mngr_ready = 1, the block SHALL drive lookup = 1 for exactly one cycle with hppa = req_addr[ADDR-1:12] and zeroBlkWr = captured req_zero_blk, then go to WAIT_ACCESS. While pgrd_mngr_ready = 0, the FSM SHALL stay in LOOKUP with lookup = 0.
REQ-015 In WAIT_ACCESS, on trnsl_reqpkt.allow_access = 1 (a single-cycle pulse), the block SHALL write {1, hppa, ppa[ADDR-1:12]} into the victim entry, advance the victim pointer modulo 4, and go to FILL_OUT with out_addr = {ppa[ADDR-1:12], req_addr[11:0]}.
REQ-016 Victim selection SHALL prefer the lowest-index invalid entry; the round-robin pointer SHALL be used only when all 4 entries are valid.
REQ-017 In HIT_OUT and FILL_OUT, out_valid SHALL stay 1 and out_addr SHALL stay stable until out_ready = 1; the FSM SHALL then return to IDLE.
REQ-018 inv_valid SHALL clear the valid bit of every entry whose hppa matches inv_hppa, in the same cycle, in any state.
REQ-019 If inv_valid hits the hppa being filled in the same cycle as allow_access, the entry SHALL NOT be written valid, but FILL_OUT SHALL still present the translated address.
REQ-020 If inv_valid hits the hppa of a request already in HIT_OUT, the held out_addr SHALL remain unchanged.
REQ-021 Hit detection SHALL be evaluated after any same-cycle invalidation; an invalidated entry SHALL never produce a hit.
REQ-022 lookup SHALL never assert outside LOOKUP, and the block SHALL never have more than one lookup outstanding.

Reset
REQ-023 On rst_ni = 0 (asynchronous), the block SHALL enter IDLE and clear all cache valid bits and the victim pointer. It SHALL drive req_ready = 0 while reset is asserted and 1 in the first cycle after release, with out_valid = 0, out_addr = 0, out_bypass = 0, lkup_reqpkt = 0 and tf_state = 0.
REQ-024 A reset asserted in WAIT_ACCESS SHALL drop the pending request; a later allow_access SHALL be ignored in IDLE.

Structure
REQ-025 The cache entry struct and the state encoding width SHALL go in hacd_pkg, as shall the TF_CACHE_ENTRIES = 4 constant; HPPA_BASE_ADDR is taken from hacd_pkg.
REQ-026 The block SHALL be a single module with no sub-modules; the CAM match logic SHALL be an inline function.

Verification
REQ-027 Scenario: miss, then pgrd_mngr_ready = 1, then allow_access with ppa = 0x8000_5000 after 20 cycles, for req_addr = HPPA_BASE_ADDR+0x1234 -> exactly one lookup pulse with hppa = HPPA_BASE_ADDR[ADDR-1:12]+1, and out_addr = 0x8000_5234.
REQ-028 Scenario: a second request to the same page at offset 0x010 -> no lookup, out_valid one cycle after the handshake, out_addr = 0x8000_5010.
REQ-029 Scenario: fill 5 distinct pages, then re-request page 1 -> page 1 misses (evicted by round-robin) and pages 2-5 hit.
REQ-030 Scenario: inv_valid with inv_hppa equal to the fill hppa, in the allow_access cycle -> FILL_OUT outputs the translated address, and the next request to that page issues a new lookup.
REQ-031 Scenario: pgrd_mngr_ready held 0 for 50 cycles -> lookup stays 0 and req_ready stays 0; lookup pulses once after ready rises.
REQ-032 Scenario: req_addr = 0x0000_1000 (below base) with out_ready stalled 3 cycles -> out_bypass = 1, out_addr = 0x0000_1000 held stable, and no lookup.
